// File: rtl/pe_conf_loader.sv
// Configuration loader for a daisy-chained row of processing elements.
// Serialises host words onto the PE weight chain, then the control chain.
module pe_conf_loader #(
    parameter int NPE   = 4,
    parameter int CL_IN = 4,
    parameter int CL1   = 2,
    parameter int M     = 4,
    parameter int KSZ   = 9,
    localparam int DW   = (M > 2*CL_IN+CL1) ? M : 2*CL_IN+CL1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             w_conf,
    output logic [M-1:0]     w_out,
    output logic             cntl_conf,
    output logic [CL_IN-1:0] bp_ch_out,
    output logic [CL_IN-1:0] d_ch_out,
    output logic [CL1-1:0]   bp_src_out,
    output logic             busy,
    output logic             done
);

    localparam int NW  = KSZ * NPE;
    localparam int WCW = $clog2(NW);
    localparam int PCW = $clog2(NPE + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WLOAD = 2'd1;
    localparam logic [1:0] S_CLOAD = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [WCW-1:0] W_LAST = WCW'(NW - 1);
    localparam logic [PCW-1:0] P_LAST = PCW'(NPE - 1);

    logic [1:0]       state_q, state_d;
    logic             then_cntl_q, then_cntl_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic             w_conf_q, w_conf_d;
    logic [M-1:0]     w_out_q, w_out_d;
    logic             cntl_conf_q, cntl_conf_d;
    logic [CL_IN-1:0] bp_ch_q, bp_ch_d;
    logic [CL_IN-1:0] d_ch_q, d_ch_d;
    logic [CL1-1:0]   bp_src_q, bp_src_d;
    logic             done_q, done_d;
    logic             xfer;

    assign s_ready = (state_q == S_WLOAD) || (state_q == S_CLOAD);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves one unassigned (no latches).
        state_d     = state_q;
        then_cntl_d = then_cntl_q;
        wcnt_d      = wcnt_q;
        pcnt_d      = pcnt_q;
        w_conf_d    = 1'b0;
        w_out_d     = w_out_q;
        cntl_conf_d = 1'b0;
        bp_ch_d     = bp_ch_q;
        d_ch_d      = d_ch_q;
        bp_src_d    = bp_src_q;
        done_d      = (state_q == S_FIN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wcnt_d      = '0;
                    pcnt_d      = '0;
                    then_cntl_d = mode[1];
                    if (mode[0])
                        state_d = S_WLOAD;
                    else if (mode[1])
                        state_d = S_CLOAD;
                end
            end
            S_WLOAD: begin
                if (xfer) begin
                    w_conf_d = 1'b1;
                    w_out_d  = s_data[M-1:0];
                    // Last weight leaves the counter parked rather than wrapping.
                    if (wcnt_q == W_LAST)
                        state_d = then_cntl_q ? S_CLOAD : S_FIN;
                    else
                        wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_CLOAD: begin
                if (xfer) begin
                    cntl_conf_d = 1'b1;
                    bp_ch_d     = s_data[CL_IN-1:0];
                    d_ch_d      = s_data[2*CL_IN-1:CL_IN];
                    bp_src_d    = s_data[2*CL_IN+CL1-1:2*CL_IN];
                    if (pcnt_q == P_LAST)
                        state_d = S_FIN;
                    else
                        pcnt_d = pcnt_q + PCW'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            then_cntl_q <= 1'b0;
            wcnt_q      <= '0;
            pcnt_q      <= '0;
            w_conf_q    <= 1'b0;
            w_out_q     <= '0;
            cntl_conf_q <= 1'b0;
            bp_ch_q     <= '0;
            d_ch_q      <= '0;
            bp_src_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            then_cntl_q <= then_cntl_d;
            wcnt_q      <= wcnt_d;
            pcnt_q      <= pcnt_d;
            w_conf_q    <= w_conf_d;
            w_out_q     <= w_out_d;
            cntl_conf_q <= cntl_conf_d;
            bp_ch_q     <= bp_ch_d;
            d_ch_q      <= d_ch_d;
            bp_src_q    <= bp_src_d;
            done_q      <= done_d;
        end
    end

    assign w_conf     = w_conf_q;
    assign w_out      = w_out_q;
    assign cntl_conf  = cntl_conf_q;
    assign bp_ch_out  = bp_ch_q;
    assign d_ch_out   = d_ch_q;
    assign bp_src_out = bp_src_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule
